// File: rtl/card_sync_master.sv
// card_sync_master: loads per-card {y,x} positions from the layout register
// file into the press checkers over a one-hot sync/done handshake, then arms
// the checkers and reports the lowest-index pressed card.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               1-cycle pulse, (re)load the full layout
//   rd_addr_o, rd_data_i  layout register file read port
//   regfile_sync_o        one-hot load strobe, one bit per checker
//   yx_position_o         position bus shared by all checkers
//   regfile_sync_done_i   per-checker load acknowledge
//   checker_enable_o      enables all checkers while armed
//   event_i               per-checker event_occurred flags
//   busy_o, ready_o       loading / armed status
//   pressed_valid_o       pulse: a press was detected
//   pressed_idx_o         lowest pressed index, held between pulses
//   multi_hit_o           more than one event bit set with the pulse
//   sync_error_o          sticky: a checker missed its ack
module card_sync_master #(
    parameter int N_CARDS = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic [IDX_W-1:0]   rd_addr_o,
    input  logic [19:0]        rd_data_i,
    output logic [N_CARDS-1:0] regfile_sync_o,
    output logic [19:0]        yx_position_o,
    input  logic [N_CARDS-1:0] regfile_sync_done_i,
    output logic               checker_enable_o,
    input  logic [N_CARDS-1:0] event_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic               pressed_valid_o,
    output logic [IDX_W-1:0]   pressed_idx_o,
    output logic               multi_hit_o,
    output logic               sync_error_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SYNC,
        WAIT_DONE,
        NEXT,
        ARMED
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [IDX_W-1:0]   rd_addr_q;
    logic [N_CARDS-1:0] sync_q;
    logic [19:0]        yx_q;
    logic               enable_q;
    logic               busy_q;
    logic               ready_q;
    logic               pvalid_q;
    logic [IDX_W-1:0]   pidx_q;
    logic               multi_q;
    logic               serr_q;

    logic [IDX_W-1:0]   hit_idx_d;
    logic               multi_d;
    logic               seen_d;
    logic [N_CARDS-1:0] strobe_d;
    logic               last_card_d;

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        hit_idx_d = '0;
        for (int i = N_CARDS - 1; i >= 0; i--) begin
            if (event_i[i]) begin
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_comb begin
        seen_d  = 1'b0;
        multi_d = 1'b0;
        for (int i = 0; i < N_CARDS; i++) begin
            if (event_i[i]) begin
                if (seen_d) begin
                    multi_d = 1'b1;
                end
                seen_d = 1'b1;
            end
        end
    end

    assign strobe_d    = N_CARDS'(1) << idx_q;
    assign last_card_d = (idx_q == IDX_W'(N_CARDS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            rd_addr_q <= '0;
            sync_q   <= '0;
            yx_q     <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            pvalid_q <= 1'b0;
            pidx_q   <= '0;
            multi_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            // Strobe and press report are single-cycle pulses.
            pvalid_q <= 1'b0;
            sync_q   <= '0;
            if (start_i) begin
                // Restart from any state; beats event handling.
                state_q   <= READ;
                idx_q     <= '0;
                rd_addr_q <= '0;
                tmo_q     <= '0;
                serr_q    <= 1'b0;
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
                enable_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    READ: begin
                        yx_q    <= rd_data_i;
                        sync_q  <= strobe_d;
                        state_q <= SYNC;
                    end
                    SYNC: begin
                        tmo_q   <= '0;
                        state_q <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (regfile_sync_done_i[idx_q]) begin
                            state_q <= NEXT;
                        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                            // Skip the card; its checker keeps the old position.
                            serr_q  <= 1'b1;
                            state_q <= NEXT;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    NEXT: begin
                        if (last_card_d) begin
                            state_q  <= ARMED;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            enable_q <= 1'b1;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            rd_addr_q <= idx_q + IDX_W'(1);
                            state_q   <= READ;
                        end
                    end
                    ARMED: begin
                        if (|event_i) begin
                            pvalid_q <= 1'b1;
                            pidx_q   <= hit_idx_d;
                            multi_q  <= multi_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_addr_o        = rd_addr_q;
    assign regfile_sync_o   = sync_q;
    assign yx_position_o    = yx_q;
    assign checker_enable_o = enable_q;
    assign busy_o           = busy_q;
    assign ready_o          = ready_q;
    assign pressed_valid_o  = pvalid_q;
    assign pressed_idx_o    = pidx_q;
    assign multi_hit_o      = multi_q;
    assign sync_error_o     = serr_q;

endmodule

// File: tb/tb_card_sync_master.sv
// tb_card_sync_master: directed + randomized bench for card_sync_master with
// behavioural checker models and a reference model of load and press report.
module tb_card_sync_master;

    localparam int N   = 16;
    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  rd_addr;
    logic [19:0] rd_data;
    logic [15:0] regfile_sync;
    logic [19:0] yx;
    logic [15:0] sync_done;
    logic        checker_enable;
    logic [15:0] event_in;
    logic        busy;
    logic        ready;
    logic        pressed_valid;
    logic [3:0]  pressed_idx;
    logic        multi_hit;
    logic        sync_error;

    logic [19:0] mem     [N];
    logic [19:0] ckpos   [N];
    logic [19:0] exp_pos [N];
    logic [15:0] nack_mask;
    logic [15:0] sq[$];
    logic [19:0] yq[$];
    int          viol;
    int          n_asserts;
    int          n_fail;
    int          m_idx;
    bit          m_multi;

    card_sync_master #(.N_CARDS(N), .IDX_W(4), .TIMEOUT(TMO)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .rd_addr_o           (rd_addr),
        .rd_data_i           (rd_data),
        .regfile_sync_o      (regfile_sync),
        .yx_position_o       (yx),
        .regfile_sync_done_i (sync_done),
        .checker_enable_o    (checker_enable),
        .event_i             (event_in),
        .busy_o              (busy),
        .ready_o             (ready),
        .pressed_valid_o     (pressed_valid),
        .pressed_idx_o       (pressed_idx),
        .multi_hit_o         (multi_hit),
        .sync_error_o        (sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Layout register file: data for the address launched this cycle.
    assign rd_data = mem[rd_addr];

    // Checker models: ack one cycle after their strobe unless muted.
    always @(posedge clk) begin
        sync_done <= regfile_sync & ~nack_mask;
        for (int i = 0; i < N; i++) begin
            if (regfile_sync[i] && !nack_mask[i]) ckpos[i] <= yx;
        end
    end

    // Strobe log and "no press report outside armed" watch.
    always @(posedge clk) begin
        #2;
        if (regfile_sync != '0) begin
            sq.push_back(regfile_sync);
            yq.push_back(yx);
        end
        if (!ready && (pressed_valid || checker_enable)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] nack);
        int l;
        l = 1;
        for (int i = 0; i < N; i++) l += 3 + (nack[i] ? TMO : 1);
        return l;
    endfunction

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = 20'($urandom);
    endtask

    task automatic pulse_start(input logic [15:0] ev);
        @(negedge clk);
        start    = 1'b1;
        event_in = ev;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", ready, 0);
        check("start_enable", checker_enable, 0);
        check("start_pvalid", pressed_valid, 0);
        check("start_serr", sync_error, 0);
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (!ready && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        event_in = '0;
    endtask

    task automatic wait_strobe(input logic [15:0] s);
        int n;
        n = 0;
        while (regfile_sync !== s && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", regfile_sync, s);
    endtask

    task automatic verify_load(input logic [15:0] nack, input int lat);
        check("latency", lat, exp_lat(nack));
        check("sync_error", sync_error, (nack != 0));
        check("strobe_count", sq.size(), N);
        for (int i = 0; i < N && i < sq.size(); i++) begin
            check($sformatf("strobe%0d", i), sq[i], 32'(16'(1) << i));
            check($sformatf("yx%0d", i), yq[i], mem[i]);
        end
        for (int i = 0; i < N; i++) begin
            if (!nack[i]) exp_pos[i] = mem[i];
            check($sformatf("ckpos%0d", i), ckpos[i], exp_pos[i]);
        end
        check("no_stray_press", viol, 0);
    endtask

    task automatic ev_step(input logic [15:0] v);
        event_in = v;
        @(negedge clk);
        event_in = '0;
        if (v != 0) begin
            m_idx   = lowest(v);
            m_multi = ($countones(v) > 1);
        end
        check("pvalid", pressed_valid, (v != 0));
        check("pidx", pressed_idx, m_idx);
        check("multi", multi_hit, m_multi);
    endtask

    initial begin
        int lat;
        logic [15:0] v;
        n_asserts = 0;
        n_fail    = 0;
        viol      = 0;
        m_idx     = 0;
        m_multi   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        event_in  = '0;
        nack_mask = '0;
        randomize_mem();
        repeat (3) @(negedge clk);

        check("rst_rd_addr", rd_addr, 0);
        check("rst_sync", regfile_sync, 0);
        check("rst_yx", yx, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_pidx", pressed_idx, 0);
        check("rst_serr", sync_error, 0);
        rst = 1'b0;

        // Full load with prompt acks.
        sq.delete(); yq.delete();
        pulse_start('0);
        wait_ready(lat);
        verify_load('0, lat);

        // Press reports while armed.
        @(negedge clk);
        ev_step(16'h0010);
        ev_step(16'h0A00);
        ev_step(16'h0000);
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = 16'(1) << $urandom_range(0, 15);
                default: v = 16'($urandom);
            endcase
            ev_step(v);
        end
        check("armed_enable", checker_enable, 1);

        // Checker 5 never acks.
        randomize_mem();
        nack_mask = 16'h0020;
        sq.delete(); yq.delete();
        pulse_start('0);
        wait_ready(lat);
        verify_load(16'h0020, lat);

        // Restart clears the sticky error.
        nack_mask = '0;
        sq.delete(); yq.delete();
        pulse_start('0);
        wait_ready(lat);
        verify_load('0, lat);

        // Restart while card 7 waits for its ack; events ignored while loading.
        randomize_mem();
        pulse_start(16'hFFFF);
        wait_strobe(16'h0080);
        sq.delete(); yq.delete();
        @(posedge clk);
        pulse_start(16'hFFFF);
        wait_ready(lat);
        verify_load('0, lat);
        @(negedge clk);
        check("no_press_after_load", pressed_valid, 0);

        // Start beats a simultaneous event while armed.
        sq.delete(); yq.delete();
        pulse_start(16'h0001);
        event_in = '0;
        wait_ready(lat);
        verify_load('0, lat);

        // Reset during card 3 strobe.
        pulse_start('0);
        wait_strobe(16'h0008);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_rd_addr", rd_addr, 0);
        check("mrst_sync", regfile_sync, 0);
        check("mrst_yx", yx, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", ready, 0);
        check("mrst_enable", checker_enable, 0);
        check("mrst_pvalid", pressed_valid, 0);
        check("mrst_pidx", pressed_idx, 0);
        check("mrst_multi", multi_hit, 0);
        check("mrst_serr", sync_error, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            event_in = 16'($urandom) | 16'h0001;
            @(negedge clk);
            check("idle_pvalid", pressed_valid, 0);
            check("idle_enable", checker_enable, 0);
            check("idle_busy", busy, 0);
        end
        event_in = '0;
        randomize_mem();
        sq.delete(); yq.delete();
        pulse_start('0);
        wait_ready(lat);
        verify_load('0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
